// File: rtl/stepper_monitor_pkg.sv
// Shared types and defaults for the stepper pulse monitor.
// Holds FSM state encoding and the default timing constants.
package stepper_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } mon_state_e;

  localparam int unsigned MIN_PULSE_WIDTH_DEF = 256;
  localparam int unsigned STUCK_TIMEOUT_DEF   = 4000000;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with rise/fall strobes on the synced level.
// Edges are held off until a genuine low has been seen after reset.
module sync_edge_detect #(
  parameter int unsigned g_Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [g_Stages-1:0] sync_q;
  logic [g_Stages-1:0] vld_q;
  logic                prev_q;
  logic                armed_q;
  logic                armed_d;
  logic                level;
  logic                vld;

  if (g_Stages < 1) begin : g_stage_chk
    $error("g_Stages must be at least 1");
  end

  assign level = sync_q[g_Stages-1];
  assign vld   = vld_q[g_Stages-1];

  // A line already high when reset releases must not look like an edge
  assign armed_d = armed_q | (vld & ~level);

  // Synchronizer chain, fill tracker and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= (sync_q << 1) | g_Stages'(d_i);
      vld_q   <= (vld_q << 1) | g_Stages'(1'b1);
      prev_q  <= level;
      armed_q <= armed_d;
    end
  end

  assign level_o = level;
  assign rise_o  = armed_q & level & ~prev_q;
  assign fall_o  = armed_q & ~level & prev_q;

endmodule

// File: rtl/stepper_pulse_monitor.sv
// Step/dir receiver: validates pulse widths, integrates position.
// Stuck-high detection is built when STEPPER_MONITOR_STUCK_EN is defined.
module stepper_pulse_monitor
  import stepper_monitor_pkg::*;
#(
  parameter int unsigned g_MinPulseWidth = MIN_PULSE_WIDTH_DEF,
  parameter int unsigned g_WidthCntBits  = 16,
  parameter int unsigned g_PositionBits  = 32,
  parameter int unsigned g_GlitchCntBits = 16,
  parameter int unsigned g_SyncStages    = 2,
  parameter int unsigned g_StuckTimeout  = STUCK_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step_i,
  input  logic                       dir_i,
  input  logic                       clear_i,
  output logic [g_PositionBits-1:0]  position_o,
  output logic                       step_ok_o,
  output logic                       glitch_o,
  output logic [g_GlitchCntBits-1:0] glitch_cnt_o,
  output logic                       dir_err_o,
  output logic [g_WidthCntBits-1:0]  last_width_o,
  output logic                       busy_o,
  output logic                       stuck_o
);

  localparam logic [g_WidthCntBits-1:0] WIDTH_MAX = '1;
  localparam logic [g_WidthCntBits-1:0] MIN_W =
    g_WidthCntBits'(g_MinPulseWidth);
  localparam logic [g_GlitchCntBits-1:0] GCNT_MAX = '1;

  if (longint'(g_MinPulseWidth) >= (longint'(1) << g_WidthCntBits))
  begin : g_min_width_chk
    $error("g_MinPulseWidth does not fit in g_WidthCntBits");
  end

  if (g_StuckTimeout == 0) begin : g_timeout_chk
    $error("g_StuckTimeout must be non-zero");
  end

  if (g_PositionBits < 2) begin : g_pos_chk
    $error("g_PositionBits must be at least 2");
  end

  logic step_s;
  logic step_rise;
  logic step_fall;
  logic dir_s;
  logic dir_rise;
  logic dir_fall;
  logic dir_chg;

  mon_state_e                 state_q, state_d;
  logic [g_WidthCntBits-1:0]  width_q, width_d;
  logic [g_WidthCntBits-1:0]  width_inc;
  logic                       dir_lat_q, dir_lat_d;
  logic [g_PositionBits-1:0]  position_q, position_d;
  logic [g_PositionBits-1:0]  pos_step;
  logic [g_GlitchCntBits-1:0] glitch_cnt_q, glitch_cnt_d;
  logic [g_WidthCntBits-1:0]  last_width_q, last_width_d;
  logic                       step_ok_q, step_ok_d;
  logic                       glitch_q, glitch_d;
  logic                       dir_err_q, dir_err_d;

`ifdef STEPPER_MONITOR_STUCK_EN
  localparam int unsigned TMO_W = $clog2(g_StuckTimeout + 1);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(g_StuckTimeout);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             stuck_q, stuck_d;
`endif

  sync_edge_detect #(
    .g_Stages (g_SyncStages)
  ) u_step_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (step_i),
    .level_o (step_s),
    .rise_o  (step_rise),
    .fall_o  (step_fall)
  );

  sync_edge_detect #(
    .g_Stages (g_SyncStages)
  ) u_dir_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (dir_i),
    .level_o (dir_s),
    .rise_o  (dir_rise),
    .fall_o  (dir_fall)
  );

  assign dir_chg = (dir_s != dir_lat_q) | dir_rise | dir_fall;

  assign width_inc = (width_q == WIDTH_MAX) ?
                     width_q : width_q + 1'b1;

  // +1 for positive direction, all-ones (-1) for negative
  assign pos_step = {{(g_PositionBits-1){~dir_lat_q}}, 1'b1};

  // Next-state and datapath update; clear overrides counter updates
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    dir_lat_d    = dir_lat_q;
    position_d   = position_q;
    glitch_cnt_d = glitch_cnt_q;
    last_width_d = last_width_q;
    step_ok_d    = 1'b0;
    glitch_d     = 1'b0;
    dir_err_d    = dir_err_q;
`ifdef STEPPER_MONITOR_STUCK_EN
    tmo_d        = tmo_q;
    stuck_d      = stuck_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (step_rise) begin
          state_d   = MEASURE;
          width_d   = g_WidthCntBits'(1);
          dir_lat_d = dir_s;
`ifdef STEPPER_MONITOR_STUCK_EN
          tmo_d     = TMO_W'(1);
`endif
        end
      end

      MEASURE: begin
        if (dir_chg) begin
          dir_err_d = 1'b1;
        end
        if (step_fall) begin
          state_d      = IDLE;
          last_width_d = width_q;
          if (width_q >= MIN_W) begin
            step_ok_d  = 1'b1;
            position_d = position_q + pos_step;
          end else begin
            glitch_d = 1'b1;
            if (glitch_cnt_q != GCNT_MAX) begin
              glitch_cnt_d = glitch_cnt_q + 1'b1;
            end
          end
        end else begin
          width_d = width_inc;
`ifdef STEPPER_MONITOR_STUCK_EN
          if (tmo_q == TMO_END) begin
            state_d = STUCK;
            stuck_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
      end

`ifdef STEPPER_MONITOR_STUCK_EN
      STUCK: begin
        width_d = width_inc;
        if (step_fall) begin
          state_d      = IDLE;
          last_width_d = WIDTH_MAX;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear_i) begin
      position_d   = '0;
      glitch_cnt_d = '0;
      dir_err_d    = 1'b0;
`ifdef STEPPER_MONITOR_STUCK_EN
      stuck_d      = 1'b0;
`endif
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      width_q      <= '0;
      dir_lat_q    <= 1'b0;
      position_q   <= '0;
      glitch_cnt_q <= '0;
      last_width_q <= '0;
      step_ok_q    <= 1'b0;
      glitch_q     <= 1'b0;
      dir_err_q    <= 1'b0;
`ifdef STEPPER_MONITOR_STUCK_EN
      tmo_q        <= '0;
      stuck_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      dir_lat_q    <= dir_lat_d;
      position_q   <= position_d;
      glitch_cnt_q <= glitch_cnt_d;
      last_width_q <= last_width_d;
      step_ok_q    <= step_ok_d;
      glitch_q     <= glitch_d;
      dir_err_q    <= dir_err_d;
`ifdef STEPPER_MONITOR_STUCK_EN
      tmo_q        <= tmo_d;
      stuck_q      <= stuck_d;
`endif
    end
  end

  assign position_o   = position_q;
  assign step_ok_o    = step_ok_q;
  assign glitch_o     = glitch_q;
  assign glitch_cnt_o = glitch_cnt_q;
  assign dir_err_o    = dir_err_q;
  assign last_width_o = last_width_q;
  assign busy_o       = (state_q != IDLE);

`ifdef STEPPER_MONITOR_STUCK_EN
  assign stuck_o = stuck_q;
`else
  assign stuck_o = 1'b0;
`endif

endmodule
